des_sbox_sequencer: RTL and testbench

Sequencer that time-multiplexes a single shared, registered DES S-box lookup port across the eight 6-bit chunks of one 48-bit round value (expanded R XOR subkey). It accepts the value on a valid/ready handshake, issues eight lookups S1..S8 in order, and assembles the returned 4-bit nibbles into the 32-bit substitution result. It sits between the round key-mix stage and the P-permutation. The block owns the S-box port exclusively.

---
 rtl/des_sbox_sequencer.sv | 108 ++++++++++
 tb/tb_des_sbox_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_sequencer.sv
// Time-multiplexes one registered DES S-box port across the eight 6-bit chunks
// of a 48-bit round value and assembles the 32-bit substitution result.
module des_sbox_sequencer #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        sbox_req,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_addr,
    input  logic [3:0]  sbox_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid/data hold until then, and ready never waits on valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_cnt;
    logic [47:0]        r_data;
    logic [31:0]        r_out;
    logic [LATENCY-1:0] r_tag_v;
    logic [2:0]         r_tag_sel [LATENCY];

    logic               w_accept;
    logic               w_req;
    logic               w_tag_hit;
    logic [2:0]         w_tag_sel;
    logic [4:0]         w_lsb;
    logic [5:0]         w_chunk;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_req     = (r_state == S_ISSUE);
    assign w_tag_hit = r_tag_v[LATENCY-1];
    assign w_tag_sel = r_tag_sel[LATENCY-1];
    // S-box sel lands in nibble 7-sel; ~sel equals 7-sel for a 3-bit index.
    assign w_lsb     = {~w_tag_sel, 2'b00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_ISSUE;
            S_ISSUE: if (r_cnt == 3'd7) w_next = S_DRAIN;
            S_DRAIN: if (w_tag_hit && (w_tag_sel == 3'd7)) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_chunk = 6'd0;
        for (int k = 0; k < 8; k++) begin
            if (r_cnt == 3'(k)) w_chunk = r_data[47-6*k -: 6];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_data  <= 48'd0;
            r_out   <= 32'd0;
            r_tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) r_tag_sel[i] <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= in_data;
                r_out  <= 32'd0;
                r_cnt  <= 3'd0;
            end else if (w_req) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_tag_hit) r_out[w_lsb +: 4] <= sbox_rdata;
            // Tag pipeline mirrors the S-box latency so each return finds its slot.
            r_tag_v[0]   <= w_req;
            r_tag_sel[0] <= r_cnt;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_sel[i] <= r_tag_sel[i-1];
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_out;
    assign sbox_req  = w_req;
    assign sbox_sel  = w_req ? r_cnt : 3'd0;
    assign sbox_addr = w_req ? w_chunk : 6'd0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: two instances (LATENCY 1 and 3), an S-box model
// returning addr[4:1], a timeline reference model and an expected-result queue.
module tb_des_sbox_sequencer;

  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk;
  logic rst;
  int   cyc;

  logic        in_valid_r [2];
  logic [47:0] in_data_r  [2];
  logic        out_ready_r[2];
  logic [3:0]  rdata0, rdata1;

  wire         in_ready_w [2];
  wire         sbox_req_w [2];
  wire  [2:0]  sbox_sel_w [2];
  wire  [5:0]  sbox_addr_w[2];
  wire         out_valid_w[2];
  wire  [31:0] out_data_w [2];
  wire         busy_w     [2];
  wire  [1:0]  dbg_w      [2];

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int n_cmp;
  int n_err;
  int drv_timeouts;
  int seen_to;

  logic        active  [2];
  int          acc_cyc [2];
  logic [47:0] acc_data[2];
  logic [31:0] held    [2];

  logic [3:0] hist0[4];
  logic [3:0] hist1[4];

  des_sbox_sequencer #(.LATENCY(L0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]), .in_data(in_data_r[0]),
    .sbox_req(sbox_req_w[0]), .sbox_sel(sbox_sel_w[0]), .sbox_addr(sbox_addr_w[0]),
    .sbox_rdata(rdata0),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_r[0]), .out_data(out_data_w[0]),
    .busy(busy_w[0]), .dbg_state(dbg_w[0])
  );

  des_sbox_sequencer #(.LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]), .in_data(in_data_r[1]),
    .sbox_req(sbox_req_w[1]), .sbox_sel(sbox_sel_w[1]), .sbox_addr(sbox_addr_w[1]),
    .sbox_rdata(rdata1),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_r[1]), .out_data(out_data_w[1]),
    .busy(busy_w[1]), .dbg_state(dbg_w[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference helpers ----------------
  function automatic logic [5:0] chunk_of(input logic [47:0] v, input int k);
    return 6'((v >> (42 - 6 * k)) & 48'h3F);
  endfunction

  function automatic logic [31:0] sbox_ref(input logic [47:0] v);
    logic [31:0] res;
    logic [5:0]  c;
    res = 32'd0;
    for (int k = 0; k < 8; k++) begin
      c   = chunk_of(v, k);
      res = {res[27:0], c[4:1]};
    end
    return res;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // ---------------- S-box model: addr[4:1] after LATENCY cycles, noise otherwise ----------------
  always @(negedge clk) begin
    for (int j = 3; j > 0; j--) begin
      hist0[j] = hist0[j-1];
      hist1[j] = hist1[j-1];
    end
    hist0[0] = sbox_req_w[0] ? sbox_addr_w[0][4:1] : 4'($urandom_range(0, 15));
    hist1[0] = sbox_req_w[1] ? sbox_addr_w[1][4:1] : 4'($urandom_range(0, 15));
    rdata0 = hist0[L0];
    rdata1 = hist1[L1];
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input int d, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int          r;
    logic        exp_req;
    logic        exp_ov;
    logic [31:0] exp_d;
    if (drv_timeouts != seen_to) begin
      chk("bounded_wait", 0, 48'(drv_timeouts), 48'(seen_to));
      seen_to = drv_timeouts;
    end
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        active[d] = 1'b0;
        held[d]   = 32'd0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (active[d]) begin
        r       = cyc - acc_cyc[d];
        exp_req = (r >= 1) && (r <= 8);
        exp_ov  = (r >= 9 + lat_of(d));
        chk("busy", d, 48'(busy_w[d]), 48'd1);
        chk("in_ready", d, 48'(in_ready_w[d]), 48'd0);
        chk("sbox_req", d, 48'(sbox_req_w[d]), 48'(exp_req));
        if (exp_req) begin
          chk("sbox_sel", d, 48'(sbox_sel_w[d]), 48'(r - 1));
          chk("sbox_addr", d, 48'(sbox_addr_w[d]), 48'(chunk_of(acc_data[d], r - 1)));
        end else begin
          chk("sel_quiet", d, 48'(sbox_sel_w[d]), 48'd0);
          chk("addr_quiet", d, 48'(sbox_addr_w[d]), 48'd0);
        end
        chk("out_valid", d, 48'(out_valid_w[d]), 48'(exp_ov));
        if (exp_ov && (q_size(d) != 0)) begin
          exp_d = (d == 0) ? exp_q0[0] : exp_q1[0];
          chk("out_data", d, 48'(out_data_w[d]), 48'(exp_d));
          if (out_ready_r[d]) begin
            if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            held[d]   = exp_d;
            active[d] = 1'b0;
          end
        end
      end else begin
        chk("idle_in_ready", d, 48'(in_ready_w[d]), 48'd1);
        chk("idle_busy", d, 48'(busy_w[d]), 48'd0);
        chk("idle_out_valid", d, 48'(out_valid_w[d]), 48'd0);
        chk("idle_sbox_req", d, 48'(sbox_req_w[d]), 48'd0);
        chk("idle_sel", d, 48'(sbox_sel_w[d]), 48'd0);
        chk("idle_addr", d, 48'(sbox_addr_w[d]), 48'd0);
        chk("idle_out_data", d, 48'(out_data_w[d]), 48'(held[d]));
        chk("idle_dbg_state", d, 48'(dbg_w[d]), 48'd0);
        if (in_valid_r[d]) begin
          active[d]   = 1'b1;
          acc_cyc[d]  = cyc;
          acc_data[d] = in_data_r[d];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_exp(input int d, input logic [47:0] data, input logic [31:0] exp);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid_r[d] = 1'b1;
    in_data_r[d]  = data;
    @(negedge clk);
    while (!in_ready_w[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid_r[d] = 1'b0;
    if (n >= 100) drv_timeouts++;
    else if (d == 0) exp_q0.push_back(exp);
    else exp_q1.push_back(exp);
  endtask

  task automatic send(input int d, input logic [47:0] data);
    send_exp(d, data, sbox_ref(data));
  endtask

  task automatic wait_done(input int d, input bit rnd_ready);
    int n;
    n = 0;
    while ((active[d] || q_size(d) != 0) && n < 400) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready_r[d] = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 400) drv_timeouts++;
    out_ready_r[d] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; drv_timeouts = 0; seen_to = 0;
    for (int d = 0; d < 2; d++) begin
      in_valid_r[d] = 1'b0; in_data_r[d] = 48'd0; out_ready_r[d] = 1'b1;
      active[d] = 1'b0; held[d] = 32'd0; acc_cyc[d] = 0; acc_data[d] = 48'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Known pattern: addresses 0,2,..,14 give nibbles 0..7.
    for (int d = 0; d < 2; d++) begin
      send_exp(d, 48'h002106_20A30E, 32'h01234567);
      wait_done(d, 1'b0);
    end

    // Consumer stall with ignored in_valid pulses.
    out_ready_r[1] = 1'b0;
    send_exp(1, 48'hFFFF_FFFF_FFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      in_valid_r[1] = (i < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data_r[1]  = rand48();
    end
    out_ready_r[1] = 1'b1;
    wait_done(1, 1'b0);

    // in_data churns after accept; lookups must use the latched value.
    for (int d = 0; d < 2; d++) begin
      send(d, rand48());
      for (int i = 0; i < 14; i++) begin
        @(posedge clk); #1;
        in_data_r[d] = rand48();
      end
      wait_done(d, 1'b0);
    end

    // Reset in cycle 5 of an operation, then a clean block.
    for (int d = 0; d < 2; d++) begin
      send(d, rand48());
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send(d, rand48());
      wait_done(d, 1'b0);
    end

    // Random traffic with random consumer back-pressure.
    for (int t = 0; t < 30; t++) begin
      int d;
      d = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(d, rand48());
      wait_done(d, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
